// File: rtl/toggle_handshake_rx.sv
// toggle_handshake_rx
// Receive side of a two-phase (toggle) request/acknowledge crossing.
// req_tgl is synchronized into the clk domain. Each level change of the
// synchronized request captures one data_in word. The word is presented on
// out_valid/out_data until the consumer takes it. Every consumed word toggles
// ack_tgl back toward the sender.
module toggle_handshake_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              ack_tgl,
    output logic [15:0]       xfer_count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Synchronizer chain. Only sync_r[0] ever looks at the asynchronous req_tgl.
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   req_s;

    state_t                 state_r;
    state_t                 state_s;
    logic                   req_seen_r;
    logic                   req_seen_s;
    logic                   valid_r;
    logic                   valid_s;
    logic [DATA_W-1:0]      data_r;
    logic [DATA_W-1:0]      data_s;
    logic                   ack_r;
    logic                   ack_s;
    logic [15:0]            cnt_r;
    logic [15:0]            cnt_s;
    logic                   pending_s;

    assign req_s      = sync_r[SYNC_STAGES-1];
    assign pending_s  = (req_s != req_seen_r);

    assign out_valid  = valid_r;
    assign out_data   = data_r;
    assign ack_tgl    = ack_r;
    assign xfer_count = cnt_r;

    // Shift the raw request through the synchronizer flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], req_tgl};
        end
    end

    // Next-state and next-output decode for the IDLE/HOLD handshake machine.
    always_comb begin
        state_s    = state_r;
        req_seen_s = req_seen_r;
        valid_s    = valid_r;
        data_s     = data_r;
        ack_s      = ack_r;
        cnt_s      = cnt_r;
        case (state_r)
            IDLE: begin
                // out_ready is deliberately not looked at here.
                if (pending_s) begin
                    data_s     = data_in;
                    req_seen_s = req_s;
                    valid_s    = 1'b1;
                    state_s    = HOLD;
                end else begin
                    state_s    = IDLE;
                    valid_s    = 1'b0;
                end
            end
            HOLD: begin
                // The request is not evaluated here. Toggles that arrive in HOLD
                // are resolved against req_seen once the machine is back in IDLE.
                if (out_ready) begin
                    ack_s   = ~ack_r;
                    cnt_s   = cnt_r + 16'd1;
                    valid_s = 1'b0;
                    state_s = IDLE;
                end else begin
                    valid_s = 1'b1;
                    state_s = HOLD;
                end
            end
            default: begin
                valid_s = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // Register state and all outputs. Reset overrides any handshake in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            req_seen_r <= 1'b0;
            valid_r    <= 1'b0;
            data_r     <= {DATA_W{1'b0}};
            ack_r      <= 1'b0;
            cnt_r      <= 16'd0;
        end else begin
            state_r    <= state_s;
            req_seen_r <= req_seen_s;
            valid_r    <= valid_s;
            data_r     <= data_s;
            ack_r      <= ack_s;
            cnt_r      <= cnt_s;
        end
    end

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Testbench for toggle_handshake_rx. Two instances share all inputs: one with
// SYNC_STAGES=2 and one with SYNC_STAGES=3. A delay-line reference model
// predicts both instances every cycle. Table vectors and hand sequences check
// the documented corner cases against fixed values.
module tb_toggle_handshake_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_tgl;
    logic [7:0]  data_in;
    logic        out_ready;

    logic        v2, v3, a2, a3;
    logic [7:0]  d2, d3;
    logic [15:0] c2, c3;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    toggle_handshake_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .reset(reset), .req_tgl(req_tgl), .data_in(data_in),
        .out_valid(v2), .out_ready(out_ready), .out_data(d2),
        .ack_tgl(a2), .xfer_count(c2)
    );

    toggle_handshake_rx #(.DATA_W(8), .SYNC_STAGES(3)) dut3 (
        .clk(clk), .reset(reset), .req_tgl(req_tgl), .data_in(data_in),
        .out_valid(v3), .out_ready(out_ready), .out_data(d3),
        .ack_tgl(a3), .xfer_count(c3)
    );

    // ---------------- reference model ----------------
    // hist[j] is req_tgl as sampled j+1 edges ago. With S stages, the
    // synchronized request seen at an edge is therefore hist[S-1].
    logic [3:0]  hist;
    logic        m_valid [2];
    logic [7:0]  m_data  [2];
    logic        m_ack   [2];
    logic [15:0] m_cnt   [2];
    logic        m_seen  [2];

    task automatic model_step();
        int stg;
        logic rs;
        if (reset) begin
            hist = 4'b0000;
            for (int i = 0; i < 2; i++) begin
                m_valid[i] = 1'b0; m_data[i] = 8'h00; m_ack[i] = 1'b0;
                m_cnt[i] = 16'h0000; m_seen[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                stg = i + 2;
                rs  = hist[stg-1];
                if (!m_valid[i]) begin
                    if (rs != m_seen[i]) begin
                        m_data[i]  = data_in;
                        m_seen[i]  = rs;
                        m_valid[i] = 1'b1;
                    end
                end else if (out_ready) begin
                    m_ack[i]   = ~m_ack[i];
                    m_cnt[i]   = m_cnt[i] + 16'd1;
                    m_valid[i] = 1'b0;
                end
            end
            hist = {hist[2:0], req_tgl};
        end
    endtask

    task automatic check_model();
        vectors++;
        if (v2 !== m_valid[0] || d2 !== m_data[0] || a2 !== m_ack[0] || c2 !== m_cnt[0]) begin
            errors++;
            $display("FAIL model_s2 t=%0t got v=%b d=%h a=%b c=%h exp v=%b d=%h a=%b c=%h",
                     $time, v2, d2, a2, c2, m_valid[0], m_data[0], m_ack[0], m_cnt[0]);
        end
        vectors++;
        if (v3 !== m_valid[1] || d3 !== m_data[1] || a3 !== m_ack[1] || c3 !== m_cnt[1]) begin
            errors++;
            $display("FAIL model_s3 t=%0t got v=%b d=%h a=%b c=%h exp v=%b d=%h a=%b c=%h",
                     $time, v3, d3, a3, c3, m_valid[1], m_data[1], m_ack[1], m_cnt[1]);
        end
    endtask

    // Apply inputs (called at a negedge), clock once, then check both instances.
    task automatic step(input logic r, input logic q, input logic [7:0] d, input logic rdy);
        reset = r; req_tgl = q; data_in = d; out_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        check_model();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic        r;
        logic        q;
        logic [7:0]  d;
        logic        rdy;
        logic        ev;
        logic [7:0]  ed;
        logic        ea;
        logic [15:0] ec;
        logic        ev3;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic       q;
        logic [7:0] dat;
        logic       last_ack;
        logic       prev_v;
        int         acks, sent, ncap, budget;
        logic [7:0] caps [4];

        reset = 1'b1; req_tgl = 1'b0; data_in = 8'h00; out_ready = 1'b0;
        hist = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0; m_data[i] = 8'h00; m_ack[i] = 1'b0;
            m_cnt[i] = 16'h0000; m_seen[i] = 1'b0;
        end

        // Single transfer of A5, then 3C held under backpressure.
        //             r     q     d      rdy   ev    ed     ea    ec        ev3
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 16'd0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 16'd1, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1, 16'd1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1, 16'd1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1, 16'd1, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 16'd1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 16'd1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 16'd1, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 16'd1, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 16'd1, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 16'd1, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 16'd2, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 16'd2, 1'b1};

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].r, tbl[i].q, tbl[i].d, tbl[i].rdy);
            check($sformatf("tbl%0d_valid", i), {31'd0, v2}, {31'd0, tbl[i].ev});
            check($sformatf("tbl%0d_data", i),  {24'd0, d2}, {24'd0, tbl[i].ed});
            check($sformatf("tbl%0d_ack", i),   {31'd0, a2}, {31'd0, tbl[i].ea});
            check($sformatf("tbl%0d_count", i), {16'd0, c2}, {16'd0, tbl[i].ec});
            check($sformatf("tbl%0d_valid_s3", i), {31'd0, v3}, {31'd0, tbl[i].ev3});
        end

        // Back-to-back: the sender toggles on each ack change, words 01..04.
        step(1'b1, 1'b0, 8'h00, 1'b1);
        q = 1'b1; dat = 8'h01; sent = 1; acks = 0; ncap = 0;
        last_ack = a2; prev_v = v2; budget = 0;
        while (acks < 4 && budget < 200) begin
            step(1'b0, q, dat, 1'b1);
            budget++;
            if (v2 && !prev_v && ncap < 4) begin
                caps[ncap] = d2;
                ncap++;
            end
            prev_v = v2;
            if (a2 != last_ack) begin
                last_ack = a2;
                acks++;
                if (sent < 4) begin
                    sent++;
                    dat = 8'(sent);
                    q = ~q;
                end
            end
        end
        check("b2b_acks", acks, 32'd4);
        check("b2b_captures", ncap, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2b_word%0d", i), {24'd0, caps[i]}, 32'(i + 1));
        end
        check("b2b_count", {16'd0, c2}, 32'd4);
        check("b2b_ack_level", {31'd0, a2}, 32'd0);

        // Reset while holding a word with out_ready high at the same edge.
        q = ~q;
        budget = 0;
        step(1'b0, q, 8'h77, 1'b0);
        while (!v2 && budget < 20) begin
            step(1'b0, q, 8'h77, 1'b0);
            budget++;
        end
        check("rst_hold_reached", {31'd0, v2}, 32'd1);
        step(1'b1, q, 8'h77, 1'b1);
        check("rst_hold_valid", {31'd0, v2}, 32'd0);
        check("rst_hold_ack", {31'd0, a2}, 32'd0);
        check("rst_hold_count", {16'd0, c2}, 32'd0);
        check("rst_hold_data", {24'd0, d2}, 32'd0);

        // Wrap: preset the counter of the 2-stage instance, then one transfer.
        // req_tgl is still high, so this release also covers detection of a
        // request that is already high when reset drops.
        force dut2.cnt_r = 16'hFFFF;
        #1;
        release dut2.cnt_r;
        m_cnt[0] = 16'hFFFF;
        last_ack = a2;
        budget = 0;
        step(1'b0, q, 8'h5A, 1'b1);
        while (a2 == last_ack && budget < 20) begin
            step(1'b0, q, 8'h5A, 1'b1);
            budget++;
        end
        check("wrap_ack_seen", {31'd0, a2}, {31'd0, ~last_ack});
        check("wrap_count", {16'd0, c2}, 32'd0);

        // Random stimulus against the reference model, including protocol abuse.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) q = ~q;
            step(($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0, q,
                 8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
